// File: rtl/mtimer_intr_gen.sv
// Machine timer (64-bit mtime/mtimecmp) and interrupt request generator.
// Issues one-cycle timer/external pulses, one in service at a time, released by mret.
module mtimer_intr_gen #(
    parameter int AW       = 5,
    parameter int PRESCALE = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    input  logic          ext_irq_i,
    input  logic          is_mret_i,
    output logic          t_intr_o,
    output logic          e_intr_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, T_FIRE, E_FIRE, SVC} state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_t      state, state_nxt;
    logic [31:0] mtime_lo, mtime_hi, cmp_lo, cmp_hi;
    logic [PW-1:0] presc;
    logic        cnt_en, tie, eie;
    logic        t_pend, e_pend, match_q;
    logic        sync1, sync2, sync3;
    logic        tick, carry, match;
    logic        wr_mtl, wr_mth, wr_cml, wr_cmh, wr_ctrl, wr_stat;
    logic        t_set, e_set, t_take, e_take, t_clr, e_clr;

    // Full-address compare also rejects non-word-aligned byte addresses.
    assign wr_mtl  = we_i && (addr_i == AW'('h00));
    assign wr_mth  = we_i && (addr_i == AW'('h04));
    assign wr_cml  = we_i && (addr_i == AW'('h08));
    assign wr_cmh  = we_i && (addr_i == AW'('h0C));
    assign wr_ctrl = we_i && (addr_i == AW'('h10));
    assign wr_stat = we_i && (addr_i == AW'('h14));

    assign tick  = cnt_en && (presc == PS_LAST);
    assign carry = tick && (mtime_lo == 32'hFFFF_FFFF);
    assign match = {mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo};

    assign t_set = match && !match_q && tie;
    assign e_set = sync2 && !sync3 && eie;
    assign t_clr = t_take || (wr_stat && wdata_i[0]);
    assign e_clr = e_take || (wr_stat && wdata_i[1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc    <= '0;
            mtime_lo <= '0;
            mtime_hi <= '0;
            cmp_lo   <= '1;
            cmp_hi   <= '1;
            cnt_en   <= 1'b0;
            tie      <= 1'b0;
            eie      <= 1'b0;
            match_q  <= 1'b0;
            t_pend   <= 1'b0;
            e_pend   <= 1'b0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
        end else begin
            if (cnt_en) presc <= tick ? '0 : presc + 1'b1;
            // A bus write to one word wins over its increment; the other word still counts.
            mtime_lo <= wr_mtl ? wdata_i : (tick  ? mtime_lo + 32'd1 : mtime_lo);
            mtime_hi <= wr_mth ? wdata_i : (carry ? mtime_hi + 32'd1 : mtime_hi);
            if (wr_cml) cmp_lo <= wdata_i;
            if (wr_cmh) cmp_hi <= wdata_i;
            if (wr_ctrl) begin
                cnt_en <= wdata_i[0];
                tie    <= wdata_i[1];
                eie    <= wdata_i[2];
            end
            match_q <= match;
            // Set has priority over any clear in the same cycle.
            t_pend  <= t_set || (t_pend && !t_clr);
            e_pend  <= e_set || (e_pend && !e_clr);
            sync1   <= ext_irq_i;
            sync2   <= sync1;
            sync3   <= sync2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        t_take    = 1'b0;
        e_take    = 1'b0;
        case (state)
            IDLE: begin
                if (t_pend && tie) begin
                    state_nxt = T_FIRE;
                    t_take    = 1'b1;
                end else if (e_pend && eie) begin
                    state_nxt = E_FIRE;
                    e_take    = 1'b1;
                end
            end
            T_FIRE:  state_nxt = SVC;
            E_FIRE:  state_nxt = SVC;
            SVC:     if (is_mret_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign t_intr_o = (state == T_FIRE);
    assign e_intr_o = (state == E_FIRE);
    assign busy_o   = (state != IDLE);

    always_comb begin
        rdata_o = '0;
        if (re_i) begin
            case (addr_i)
                AW'('h00): rdata_o = mtime_lo;
                AW'('h04): rdata_o = mtime_hi;
                AW'('h08): rdata_o = cmp_lo;
                AW'('h0C): rdata_o = cmp_hi;
                AW'('h10): rdata_o = {29'd0, eie, tie, cnt_en};
                AW'('h14): rdata_o = {29'd0, busy_o, e_pend, t_pend};
                default:   rdata_o = '0;
            endcase
        end
    end

endmodule

// File: doc/mtimer_intr_gen.md
# mtimer_intr_gen

- Machine-timer and interrupt-request generator that drives the timer and external interrupt inputs of the CSR register file.
- Holds a 64-bit mtime counter and a 64-bit mtimecmp register, both memory-mapped as 32-bit words.
- Synchronises and edge-detects an asynchronous external IRQ line.
- Issues one-cycle interrupt pulses to the core, allowing at most one interrupt in service, and waits for mret before issuing the next.

## Interface
- AW, 5, register address width (byte address).
- PRESCALE, 1, clk_i cycles per mtime increment; legal range ≥1.
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- addr_i  in  AW  byte address of the register access.
- we_i  in  1  write strobe.
- re_i  in  1  read strobe.
- wdata_i  in  32  write data.
- rdata_o  out  32  combinational read data; 0 when re_i=0 or the address is unmapped.
- ext_irq_i  in  1  asynchronous external interrupt level.
- is_mret_i  in  1  core retiring mret (end of service).
- t_intr_o  out  1  timer interrupt pulse to the CSR file.
- e_intr_o  out  1  external interrupt pulse to the CSR file.
- busy_o  out  1  interrupt issued and not yet retired.

## Operation
- **Register map.** Word addresses; byte addresses with addr_i[1:0]≠0 are unmapped.
  - 0x00 mtime[31:0], RW.
  - 0x04 mtime[63:32], RW.
  - 0x08 mtimecmp[31:0], RW.
  - 0x0C mtimecmp[63:32], RW.
  - 0x10 ctrl, RW: bit0 cnt_en, bit1 tie, bit2 eie; other bits read 0.
  - 0x14 status: bit0 t_pend (W1C), bit1 e_pend (W1C), bit2 busy (RO).
  - Unmapped writes are ignored.
- **Reset values.** mtime=0, mtimecmp=all-ones, ctrl=0, pendings=0, prescaler=0, synchroniser flops=0, FSM=IDLE. All outputs 0.
- **Prescaler.**
  - Counts 0..PRESCALE-1 while cnt_en=1 and holds its value while cnt_en=0.
  - The tick is asserted in the cycle it equals PRESCALE-1; it wraps to 0 on that edge.
  - PRESCALE=1 gives a tick every enabled cycle.
- **mtime.**
  - 64-bit increment on tick, with carry from the low word into the high word.
  - Wraps from 2^64-1 to 0.
  - A bus write to a word of mtime overrides that word's increment in the same cycle; the other word still receives carry or increment.
- **Timer match.**
  - match = (mtime >= mtimecmp), unsigned 64-bit, computed from registered values.
  - match_q is the registered copy of match.
  - t_pend sets on the rising edge of match (match && !match_q) when tie=1.
  - Rewriting mtimecmp above mtime drops match and re-arms the rising-edge detection.
- **External interrupt.**
  - Two-flop synchroniser on ext_irq_i, followed by a third flop for edge detection.
  - A rising edge of the synchronised level sets e_pend when eie=1.
- **Pending clear.**
  - Writing 1 to a W1C status bit clears that bit.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **FSM states.** IDLE, T_FIRE, E_FIRE, SVC.
  - IDLE→T_FIRE when t_pend && tie. Clears t_pend.
  - Otherwise IDLE→E_FIRE when e_pend && eie. Clears e_pend. Timer has priority over external.
  - T_FIRE→SVC and E_FIRE→SVC unconditionally after one cycle.
  - SVC→IDLE when is_mret_i=1.
  - is_mret_i is ignored in IDLE, T_FIRE and E_FIRE.
  - Events arriving in any state latch into the pending bits; nothing is lost while busy.
- **Output decode.** All outputs are decoded from the registered state, so they are glitch-free.
  - t_intr_o = (state==T_FIRE).
  - e_intr_o = (state==E_FIRE).
  - busy_o = (state!=IDLE).
- **Enable changes.** Clearing tie or eie leaves an already-set pending bit set but not issued; re-enabling issues it.

## Timing
- **Bus.** Writes take effect at the clock edge where we_i=1. Reads are combinational from current register values.
- **Timer latency.**
  - mtime reaches mtimecmp at edge N, so match=1 during cycle N.
  - t_pend is set at edge N+1.
  - T_FIRE is entered at edge N+2; t_intr_o is high for exactly one cycle.
- **External latency.**
  - ext_irq_i is first sampled high at edge k.
  - e_pend is set at edge k+2.
  - E_FIRE is entered at edge k+3; e_intr_o is high for one cycle.
  - Pulses narrower than one clock period may be missed; this is allowed.
- **Back-to-back.**
  - After is_mret_i is accepted in SVC, IDLE lasts at least one cycle.
  - The next FIRE is therefore no earlier than 2 cycles after the mret edge.
  - t_intr_o and e_intr_o are never both high, and are never high in consecutive cycles.
- **Mid-operation reset.** Asserting rst_ni low at any time forces the reset values asynchronously; outputs drop within the same cycle.

## Test plan
- **Reset and read-back.** Reset, then read 0x00–0x14. Expect: mtime 0, mtimecmp words 0xFFFFFFFF, ctrl 0, status 0, and all outputs 0.
- **Timer fire.**
  - Stimulus: PRESCALE=1; write mtimecmp=10; ctrl=0x3.
  - Expect: mtime equals 10 at edge N; t_intr_o is a single-cycle pulse at edge N+2; busy_o stays 1 until is_mret_i; busy_o goes 0 one edge after mret.
- **Carry and wrap.**
  - Write mtime lo=0xFFFFFFFF, hi=0 → after one tick, hi=1 and lo=0.
  - Write both words 0xFFFFFFFF → after one tick, mtime=0.
- **External edge.** eie=1; raise ext_irq_i at edge k → e_intr_o pulses at edge k+3 with a one-cycle width. Holding ext_irq_i high produces no second pulse.
- **Simultaneous and busy.**
  - Timer and external events both pending in IDLE: t_intr_o is issued first.
  - e_intr_o follows only after is_mret_i, at the mret edge +2.
  - During SVC, status reads 0x6.
- **W1C and reset mid-service.**
  - Write 0x1 to status while t_pend=1 → t_pend clears and no pulse is issued.
  - Assert rst_ni low during SVC → busy_o falls to 0 immediately and all registers return to their reset values.
